mbr_mem_if: RTL and testbench
=============================

MBR_MEM_IF -- requirements
Module: mbr_mem_if

Interface
REQ-001 SHALL have parameter DW, default 16, meaning data width shared with the buffer register stage.
REQ-002 SHALL have parameter AW, default 8, meaning memory address width.
REQ-003 SHALL have parameter TIMEOUT, default 15, meaning maximum wait cycles for mem_ready.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 control_signals  in  16  CU microcontrol word: bit0 RD (MEM->MBR), bit1 WR (MBR->MEM), bit2 LDA (ACC->MBR), bit9 CLR_ERR.
REQ-007 mar_addr  in  AW  address from MAR.
REQ-008 acc2mbr  in  DW  accumulator value.
REQ-009 mem_rdata  in  DW  memory read data, valid when mem_ready=1.
REQ-010 mem_ready  in  1  memory completion strobe.
REQ-011 mem_req  out  1  memory request, held until completion or timeout.
REQ-012 mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
REQ-013 mem_addr  out  AW  registered access address.
REQ-014 mem_wdata  out  DW  registered write data.
REQ-015 mbr2br  out  DW  MBR contents, feeding BR/IR/ACC.
REQ-016 busy  out  1  CU stall; 1 whenever state != IDLE.
REQ-017 done  out  1  one-cycle pulse on access completion.
REQ-018 timeout_err  out  1  sticky timeout flag.

Function
REQ-019 FSM SHALL have states IDLE, RD_WAIT, WR_WAIT.
REQ-020 In IDLE, command priority SHALL be RD > WR > LDA; lower-priority bits asserted in the same cycle are dropped.
REQ-021 IDLE+RD: latch mar_addr into mem_addr, set mem_req=1, mem_we=0, clear wait counter, go RD_WAIT.
REQ-022 IDLE+WR: latch mar_addr and current MBR into mem_addr/mem_wdata, set mem_req=1, mem_we=1, clear counter, go WR_WAIT.
REQ-023 IDLE+LDA: MBR <= acc2mbr on that edge; state stays IDLE; done SHALL NOT pulse.
REQ-024 RD_WAIT with mem_ready=1: MBR <= mem_rdata, mem_req <= 0, done <= 1 for one cycle, go IDLE.
REQ-025 WR_WAIT with mem_ready=1: mem_req <= 0, mem_we <= 0, done pulse, go IDLE; MBR unchanged.
REQ-026 Counter SHALL increment each wait cycle without mem_ready; when it reaches TIMEOUT-1 without ready: mem_req <= 0, timeout_err <= 1, go IDLE, MBR unchanged, no done pulse.
REQ-027 mem_ready in the same cycle as the timeout limit SHALL count as completion, not timeout.
REQ-028 mem_ready while in IDLE SHALL be ignored.
REQ-029 All control_signals bits SHALL be ignored while busy=1, including the completion cycle; a new command is accepted no earlier than the cycle after return to IDLE.
REQ-030 Read access latency: mem_req rises 1 cycle after RD is sampled; MBR updates on the edge sampling mem_ready; minimum RD-to-data 2 cycles.
REQ-031 CLR_ERR SHALL clear timeout_err in any state; if a timeout occurs in the same cycle, set wins.
REQ-032 mbr2br SHALL change only on REQ-023/REQ-024 edges, stable otherwise so BR may load it any cycle.
REQ-033 busy SHALL be combinational from state; all other outputs registered.

Reset
REQ-034 On rst=1 at a clock edge: state IDLE, MBR 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, done 0, timeout_err 0, counter 0.
REQ-035 Reset mid-access SHALL drop mem_req on the same edge with no done pulse; rst SHALL dominate all commands.

Structure
REQ-036 Control-bit indices (RD, WR, LDA, CLR_ERR, BR load bit 8) and FSM state encoding SHALL live in shared package cpu_ctrl_pkg.
REQ-037 Wait counter SHALL be sub-module mem_wait_timer (clear, enable, expired output); everything else inline.

Verification
REQ-038 RD with mar_addr=0x12, mem_ready after 3 cycles with mem_rdata=0xBEEF -> mem_addr=0x12, mem_we=0, mbr2br=0xBEEF, one done pulse, busy high exactly during wait.
REQ-039 LDA with acc2mbr=0x00A5, then WR to 0x40 with ready after 1 cycle -> mem_wdata=0x00A5, mem_we=1, mbr2br remains 0x00A5.
REQ-040 RD with mem_ready never asserted -> mem_req drops after TIMEOUT cycles, timeout_err=1, no done, MBR unchanged; CLR_ERR -> timeout_err=0.
REQ-041 RD+WR+LDA in same cycle -> read only; RD asserted during RD_WAIT -> ignored, single access.
REQ-042 rst=1 in RD_WAIT -> all outputs per REQ-034 next cycle; late mem_ready afterwards ignored.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Control-word bit positions and memory-interface FSM encoding shared by the
// CU-side blocks of the CPU.
package cpu_ctrl_pkg;

    localparam int CTRL_W       = 16;
    localparam int CTRL_RD      = 0;
    localparam int CTRL_WR      = 1;
    localparam int CTRL_LDA     = 2;
    localparam int CTRL_BR_LD   = 8;
    localparam int CTRL_CLR_ERR = 9;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2
    } mem_state_e;

    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_RD   = 2'd1,
        CMD_WR   = 2'd2,
        CMD_LDA  = 2'd3
    } mem_cmd_e;

    // Fixed priority RD > WR > LDA; lower-priority bits in the same word are dropped.
    function automatic mem_cmd_e decode_cmd(input logic rd, input logic wr, input logic lda);
        if (rd)       return CMD_RD;
        else if (wr)  return CMD_WR;
        else if (lda) return CMD_LDA;
        else          return CMD_NONE;
    endfunction

endpackage

// File: rtl/mbr_mem_if_if.sv
// Memory bus between the MBR/memory interface (master) and the memory (slave).
interface mbr_mem_bus_if #(
    parameter int DW = 16,
    parameter int AW = 8
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for memory accesses; expired flags the last permitted
// wait cycle (count == TIMEOUT-1).
module mem_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign expired = (count_q == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mbr.sv
// Memory buffer register and memory access sequencer: turns CU RD/WR/LDA
// microcommands into single memory transactions with a bounded wait.
module mbr_mem_if
    import cpu_ctrl_pkg::*;
#(
    parameter int DW      = 16,
    parameter int AW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CTRL_W-1:0] control_signals,
    input  logic [AW-1:0]     mar_addr,
    input  logic [DW-1:0]     acc2mbr,
    output logic [DW-1:0]     mbr2br,
    output logic              busy,
    output logic              done,
    output logic              timeout_err,
    mbr_mem_bus_if.master     mem
);
    mem_state_e    state_q, state_d;
    logic [DW-1:0] mbr_q, mbr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          tmr_clear, tmr_enable, tmr_expired;
    logic          timeout_hit;
    mem_cmd_e      cmd;
    logic          unused_ctrl;

    // Remaining control bits belong to other datapath blocks.
    assign unused_ctrl = ^control_signals;

    assign cmd = decode_cmd(control_signals[CTRL_RD], control_signals[CTRL_WR],
                            control_signals[CTRL_LDA]);

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mbr_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mbr_q   <= mbr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            req_q   <= req_d;
            we_q    <= we_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mbr_d       = mbr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        req_d       = req_q;
        we_d        = we_q;
        done_d      = 1'b0;
        tmr_clear   = 1'b0;
        tmr_enable  = 1'b0;
        timeout_hit = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                unique case (cmd)
                    CMD_RD: begin
                        addr_d    = mar_addr;
                        req_d     = 1'b1;
                        we_d      = 1'b0;
                        tmr_clear = 1'b1;
                        state_d   = ST_RD_WAIT;
                    end
                    CMD_WR: begin
                        addr_d    = mar_addr;
                        wdata_d   = mbr_q;
                        req_d     = 1'b1;
                        we_d      = 1'b1;
                        tmr_clear = 1'b1;
                        state_d   = ST_WR_WAIT;
                    end
                    CMD_LDA:  mbr_d = acc2mbr;
                    default:  ;
                endcase
            end
            // Ready on the expiry cycle still completes the access.
            ST_RD_WAIT: begin
                if (mem.mem_ready) begin
                    mbr_d   = mem.mem_rdata;
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (tmr_expired) begin
                    req_d       = 1'b0;
                    timeout_hit = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    tmr_enable = 1'b1;
                end
            end
            ST_WR_WAIT: begin
                if (mem.mem_ready) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (tmr_expired) begin
                    req_d       = 1'b0;
                    we_d        = 1'b0;
                    timeout_hit = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    tmr_enable = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // CLR_ERR acts in every state; a simultaneous timeout takes precedence.
        if (timeout_hit) begin
            err_d = 1'b1;
        end else if (control_signals[CTRL_CLR_ERR]) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign timeout_err   = err_q;
    assign mbr2br        = mbr_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
endmodule

// File: tb/tb_mbr_mem_if.sv
// Directed bench for mbr_mem_if: read, LDA/write, priority, timeout,
// ready-at-limit, clear/set race and mid-access reset.
module tb_mbr_mem_if;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int TIMEOUT = 15;

    localparam logic [15:0] C_RD  = 16'h0001;
    localparam logic [15:0] C_WR  = 16'h0002;
    localparam logic [15:0] C_LDA = 16'h0004;
    localparam logic [15:0] C_CLR = 16'h0200;

    logic          clk;
    logic          rst;
    logic [15:0]   control_signals;
    logic [AW-1:0] mar_addr;
    logic [DW-1:0] acc2mbr;
    logic [DW-1:0] mbr2br;
    logic          busy;
    logic          done;
    logic          timeout_err;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    logic seen_done;

    mbr_mem_bus_if #(.DW(DW), .AW(AW)) mem_bus ();

    mbr_mem_if #(.DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk             (clk),
        .rst             (rst),
        .control_signals (control_signals),
        .mar_addr        (mar_addr),
        .acc2mbr         (acc2mbr),
        .mbr2br          (mbr2br),
        .busy            (busy),
        .done            (done),
        .timeout_err     (timeout_err),
        .mem             (mem_bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        control_signals = '0;
        mar_addr = '0;
        acc2mbr = '0;
        mem_bus.mem_rdata = '0;
        mem_bus.mem_ready = 1'b0;
        tick();
        tick();
        check("rst_req",   32'(mem_bus.mem_req),   32'd0);
        check("rst_we",    32'(mem_bus.mem_we),    32'd0);
        check("rst_addr",  32'(mem_bus.mem_addr),  32'd0);
        check("rst_wdata", 32'(mem_bus.mem_wdata), 32'd0);
        check("rst_mbr",   32'(mbr2br),            32'd0);
        check("rst_done",  32'(done),              32'd0);
        check("rst_err",   32'(timeout_err),       32'd0);
        check("rst_busy",  32'(busy),              32'd0);
        rst = 1'b0;

        // Read from 0x12; RD kept asserted through the wait and completion.
        control_signals = C_RD; mar_addr = 8'h12;
        tick();
        check("rd_busy",  32'(busy),             32'd1);
        check("rd_req",   32'(mem_bus.mem_req),  32'd1);
        check("rd_we",    32'(mem_bus.mem_we),   32'd0);
        check("rd_addr",  32'(mem_bus.mem_addr), 32'h12);
        check("rd_done0", 32'(done),             32'd0);
        mar_addr = 8'h77;
        tick();
        check("rd_addr_hold", 32'(mem_bus.mem_addr), 32'h12);
        check("rd_busy_w",    32'(busy),             32'd1);
        tick();
        mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 16'hBEEF;
        tick();
        check("rd_mbr",    32'(mbr2br),           32'hBEEF);
        check("rd_done",   32'(done),             32'd1);
        check("rd_req_lo", 32'(mem_bus.mem_req),  32'd0);
        check("rd_idle",   32'(busy),             32'd0);
        mem_bus.mem_ready = 1'b0; control_signals = '0;
        tick();
        check("rd_done_1cyc", 32'(done),            32'd0);
        check("rd_no_reissue", 32'(mem_bus.mem_req), 32'd0);
        check("rd_mbr_hold",  32'(mbr2br),           32'hBEEF);

        // LDA then write to 0x40.
        control_signals = C_LDA; acc2mbr = 16'h00A5;
        tick();
        check("lda_mbr",  32'(mbr2br), 32'h00A5);
        check("lda_done", 32'(done),   32'd0);
        check("lda_busy", 32'(busy),   32'd0);
        control_signals = C_WR; mar_addr = 8'h40; acc2mbr = 16'h1111;
        tick();
        control_signals = '0;
        check("wr_busy",  32'(busy),              32'd1);
        check("wr_req",   32'(mem_bus.mem_req),   32'd1);
        check("wr_we",    32'(mem_bus.mem_we),    32'd1);
        check("wr_addr",  32'(mem_bus.mem_addr),  32'h40);
        check("wr_wdata", 32'(mem_bus.mem_wdata), 32'h00A5);
        tick();
        mem_bus.mem_ready = 1'b1;
        tick();
        check("wr_done",   32'(done),            32'd1);
        check("wr_req_lo", 32'(mem_bus.mem_req), 32'd0);
        check("wr_we_lo",  32'(mem_bus.mem_we),  32'd0);
        check("wr_mbr",    32'(mbr2br),          32'h00A5);

        // Ready while idle is ignored.
        mem_bus.mem_rdata = 16'h1234;
        tick();
        check("idle_rdy_mbr",  32'(mbr2br), 32'h00A5);
        check("idle_rdy_done", 32'(done),   32'd0);
        mem_bus.mem_ready = 1'b0;

        // RD+WR+LDA together: read only.
        control_signals = C_RD | C_WR | C_LDA; mar_addr = 8'h33; acc2mbr = 16'h5555;
        tick();
        control_signals = '0;
        check("pri_we",   32'(mem_bus.mem_we),   32'd0);
        check("pri_addr", 32'(mem_bus.mem_addr), 32'h33);
        check("pri_mbr",  32'(mbr2br),           32'h00A5);
        mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 16'h0F0F;
        tick();
        mem_bus.mem_ready = 1'b0;
        check("pri_rd_mbr", 32'(mbr2br), 32'h0F0F);
        tick();

        // Read with no ready: timeout after TIMEOUT wait cycles.
        control_signals = C_RD; mar_addr = 8'h55;
        tick();
        control_signals = '0;
        seen_done = 1'b0;
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            tick();
            seen_done = seen_done | done;
        end
        check("to_req_last", 32'(mem_bus.mem_req), 32'd1);
        check("to_err_pre",  32'(timeout_err),     32'd0);
        tick();
        seen_done = seen_done | done;
        check("to_req_drop", 32'(mem_bus.mem_req), 32'd0);
        check("to_err",      32'(timeout_err),     32'd1);
        check("to_no_done",  32'(seen_done),       32'd0);
        check("to_busy",     32'(busy),            32'd0);
        check("to_mbr",      32'(mbr2br),          32'h0F0F);
        control_signals = C_CLR;
        tick();
        control_signals = '0;
        check("clr_err", 32'(timeout_err), 32'd0);

        // Ready on the expiry cycle counts as completion.
        control_signals = C_RD; mar_addr = 8'h66;
        tick();
        control_signals = '0;
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 16'hCAFE;
        tick();
        mem_bus.mem_ready = 1'b0;
        check("lim_done", 32'(done),        32'd1);
        check("lim_mbr",  32'(mbr2br),      32'hCAFE);
        check("lim_err",  32'(timeout_err), 32'd0);

        // CLR_ERR in the timeout cycle: set wins.
        control_signals = C_RD; mar_addr = 8'h67;
        tick();
        control_signals = '0;
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        control_signals = C_CLR;
        tick();
        control_signals = '0;
        check("race_err", 32'(timeout_err), 32'd1);

        // Reset in the middle of a read; late ready is ignored.
        control_signals = C_RD; mar_addr = 8'h99;
        tick();
        control_signals = '0;
        tick();
        check("mid_req", 32'(mem_bus.mem_req), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_req",   32'(mem_bus.mem_req),   32'd0);
        check("mrst_we",    32'(mem_bus.mem_we),    32'd0);
        check("mrst_addr",  32'(mem_bus.mem_addr),  32'd0);
        check("mrst_wdata", 32'(mem_bus.mem_wdata), 32'd0);
        check("mrst_mbr",   32'(mbr2br),            32'd0);
        check("mrst_done",  32'(done),              32'd0);
        check("mrst_err",   32'(timeout_err),       32'd0);
        check("mrst_busy",  32'(busy),              32'd0);
        mem_bus.mem_ready = 1'b1; mem_bus.mem_rdata = 16'hDEAD;
        tick();
        mem_bus.mem_ready = 1'b0;
        check("late_rdy_mbr",  32'(mbr2br), 32'd0);
        check("late_rdy_done", 32'(done),   32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
